// File: rtl/spill_rr_arbiter_flush.sv
// Round-robin N:1 arbiter into a 2-entry spill buffer with a 4-phase flush that discards buffered beats.
// One cycle from input handshake to oup_valid_o; inputs stall when both entries are full or a flush is in progress.
module spill_rr_arbiter_flush #(
  parameter int unsigned NumInp    = 4,
  parameter int unsigned DataWidth = 32,
  localparam int unsigned IdxWidth = $clog2(NumInp)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumInp-1:0]           inp_valid_i,
  output logic [NumInp-1:0]           inp_ready_o,
  input  logic [NumInp*DataWidth-1:0] inp_data_i,
  output logic                        oup_valid_o,
  input  logic                        oup_ready_i,
  output logic [DataWidth-1:0]        oup_data_o,
  output logic [IdxWidth-1:0]         oup_idx_o,
  input  logic                        flush_req_i,
  output logic                        flush_ack_o,
  output logic [1:0]                  occupancy_o,
  output logic [1:0]                  dropped_o
);

  typedef struct packed {
    logic [IdxWidth-1:0]  idx;
    logic [DataWidth-1:0] dat;
  } entry_t;

  typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_ACK} state_t;

  state_t              r_state;
  logic                r_a_full, r_b_full;
  entry_t              r_a, r_b;
  logic [IdxWidth-1:0] r_rr;
  logic [1:0]          r_dropped;

  logic                w_any_vld, w_hi_vld;
  logic [IdxWidth-1:0] w_lo_idx, w_hi_idx, w_gnt_idx;
  logic [DataWidth-1:0] w_sel_dat;
  logic                w_can_accept, w_accept;
  logic                w_oup_valid, w_oup_hs, w_a_leave, w_b_leave;
  logic [1:0]          w_occ;

  // Scan from the top down so the last hit is the lowest index; the "hi" search
  // only considers indices at or above the round-robin pointer.
  always_comb begin
    w_any_vld = 1'b0;
    w_hi_vld  = 1'b0;
    w_lo_idx  = '0;
    w_hi_idx  = '0;
    for (int g = int'(NumInp) - 1; g >= 0; g--) begin
      if (inp_valid_i[g]) begin
        w_any_vld = 1'b1;
        w_lo_idx  = IdxWidth'(g);
        if (IdxWidth'(g) >= r_rr) begin
          w_hi_vld = 1'b1;
          w_hi_idx = IdxWidth'(g);
        end
      end
    end
  end

  assign w_gnt_idx    = w_hi_vld ? w_hi_idx : w_lo_idx;
  assign w_can_accept = (r_state == ST_IDLE) && !(r_a_full && r_b_full);
  assign w_accept     = w_can_accept && w_any_vld;

  always_comb begin
    inp_ready_o = '0;
    w_sel_dat   = '0;
    for (int g = 0; g < int'(NumInp); g++) begin
      if (w_gnt_idx == IdxWidth'(g)) begin
        inp_ready_o[g] = w_accept;
        w_sel_dat      = inp_data_i[g*DataWidth +: DataWidth];
      end
    end
  end

  assign w_oup_valid = (r_state == ST_IDLE) && (r_a_full || r_b_full);
  assign w_oup_hs    = w_oup_valid && oup_ready_i;
  assign w_a_leave   = w_oup_hs && !r_b_full;
  assign w_b_leave   = w_oup_hs && r_b_full;
  assign w_occ       = {1'b0, r_a_full} + {1'b0, r_b_full};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_a_full  <= 1'b0;
      r_b_full  <= 1'b0;
      r_rr      <= '0;
      r_dropped <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a_full <= 1'b1;
            r_rr     <= (w_gnt_idx == IdxWidth'(NumInp - 1)) ? '0 : w_gnt_idx + 1'b1;
            if (r_a_full && !w_a_leave) r_b_full <= 1'b1;
          end else if (w_a_leave) begin
            r_a_full <= 1'b0;
          end
          // B only drains when full, and only refills when empty, so this never collides with the fill above.
          if (w_b_leave) r_b_full <= 1'b0;
          if (flush_req_i) r_state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          r_a_full  <= 1'b0;
          r_b_full  <= 1'b0;
          r_dropped <= w_occ;
          r_rr      <= '0;
          r_state   <= ST_ACK;
        end
        ST_ACK: begin
          if (!flush_req_i) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_a <= '{idx: w_gnt_idx, dat: w_sel_dat};
      if (r_a_full && !w_a_leave) r_b <= r_a;
    end
  end

  assign oup_valid_o = w_oup_valid;
  assign oup_data_o  = r_b_full ? r_b.dat : r_a.dat;
  assign oup_idx_o   = r_b_full ? r_b.idx : r_a.idx;
  assign flush_ack_o = (r_state == ST_ACK);
  assign occupancy_o = w_occ;
  assign dropped_o   = r_dropped;

endmodule
